// File: rtl/clk_div_bank.sv
// Bank of NCH runtime-programmable integer clock dividers behind a PLL-style lock stage.
// Divisor changes are staged and applied at each channel's terminal count so that no period is cut short.
module clk_div_bank #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 8,
  parameter int LOCK_CYCLES = 1024,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clkin,
  input  logic             reset_n,
  input  logic [NCH-1:0]   ch_en,
  input  logic             resync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             locked,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   tick
);

  localparam int               LK_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LK_W-1:0]  LOCK_LAST = LK_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);

  typedef enum logic {LOCKING, RUN} state_e;

  state_e state_q, state_d;
  logic [LK_W-1:0] lock_cnt_q;
  logic            lock_done;

  logic [NCH-1:0][DIV_W-1:0] div_q, div_d;
  logic [NCH-1:0][DIV_W-1:0] pdiv_q, pdiv_d;
  logic [NCH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]            pend_q, pend_d;
  logic [NCH-1:0]            act_q, act_d;
  logic [NCH-1:0]            clk_d, tick_d;

  logic in_run, run_d, resync_run;
  logic ch_ok, bad_req, sel_pend, accept, good;

  // Rounded-up half period: an odd divisor gets the extra cycle in its high phase.
  function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] n);
    return (n >> 1) + {{(DIV_W-1){1'b0}}, n[0]};
  endfunction

  // ---------------- lock FSM ----------------
  always_ff @(posedge clkin or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!reset_n) state_q <= LOCKING;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    if (state_q == LOCKING && lock_done) state_d = RUN;
  end

  always_comb begin
    locked = (state_q == RUN);
  end

  assign lock_done = (lock_cnt_q == LOCK_LAST);

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n)                              lock_cnt_q <= '0;
    else if (state_q == LOCKING && !lock_done) lock_cnt_q <= lock_cnt_q + LK_W'(1);
  end

  assign in_run     = (state_q == RUN);
  assign run_d      = (state_d == RUN);
  assign resync_run = resync && in_run;

  // ---------------- config port ----------------
  assign ch_ok   = ({1'b0, cfg_ch} < (CH_W+1)'(NCH));
  assign bad_req = !ch_ok || (cfg_div < DIV_MIN);

  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) sel_pend = pend_q[i];
    end
  end

  // Rejected requests always complete so a bad request can never stall the port.
  assign cfg_ready = bad_req || !sel_pend;
  assign accept    = cfg_valid && cfg_ready;
  assign good      = accept && !bad_req;

  // ---------------- channel next-state ----------------
  always_comb begin
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    act_d  = '0;
    clk_d  = '0;
    tick_d = '0;
    for (int i = 0; i < NCH; i++) begin
      logic hit, wrap;
      hit      = good && (cfg_ch == CH_W'(i));
      wrap     = act_q[i] && (cnt_q[i] == div_q[i] - DIV_ONE);
      act_d[i] = run_d && ch_en[i];

      if (!in_run || !act_q[i] || resync_run) begin
        // Idle channel or realign: the divisor (new or staged) takes effect immediately.
        if (hit)            div_d[i] = cfg_div;
        else if (pend_q[i]) div_d[i] = pdiv_q[i];
        pend_d[i] = 1'b0;
      end else if (wrap) begin
        // A request landing on the terminal count waits for the next one.
        if (pend_q[i]) div_d[i] = pdiv_q[i];
        pend_d[i] = hit;
        if (hit) pdiv_d[i] = cfg_div;
      end else if (hit) begin
        pend_d[i] = 1'b1;
        pdiv_d[i] = cfg_div;
      end

      if (!act_d[i] || !act_q[i] || resync_run || wrap) cnt_d[i] = '0;
      else                                              cnt_d[i] = cnt_q[i] + DIV_ONE;

      // Outputs are registered from next-state so they line up with the cnt register.
      clk_d[i]  = act_d[i] && (cnt_d[i] < half_up(div_d[i]));
      tick_d[i] = act_d[i] && (cnt_d[i] == div_d[i] - DIV_ONE);
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the divisor bank is plain flops, not RAM, so it can take DEFAULT_DIV on reset.
      div_q   <= {NCH{DIV_RST}};
      pdiv_q  <= {NCH{DIV_RST}};
      pend_q  <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
      clkout  <= '0;
      tick    <= '0;
      cfg_err <= 1'b0;
    end else begin
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      clkout  <= clk_d;
      tick    <= tick_d;
      cfg_err <= accept && bad_req;
    end
  end

endmodule
